// File: rtl/led_display_pkg.sv
// Shared types and helpers for the LED index display: FSM states, difficulty codes, idle bar pattern.
// Pure declarations, no timing.
package led_display_pkg;

    typedef enum logic [1:0] {
        S_MODE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_SWEEP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_LOW  = 2'd1,
        MODE_NORM = 2'd2,
        MODE_HIGH = 2'd3
    } mode_t;

    // Bits [n-4:3] set: a centred bar that leaves three dark LEDs at each end.
    function automatic logic [31:0] idle_pattern(input int n);
        idle_pattern = '0;
        for (int i = 3; i <= n - 4; i++) begin
            idle_pattern[i] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider with enable and clear; tick pulses for one cycle while cnt sits at DIV-1.
// Tick is combinational from the count and enable; clear only affects the next count value.
module tick_divider #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/led_index_display.sv
// LED bar driver: mode bar when stopped, one-hot position when running, blinking position when paused.
// All outputs registered, one cycle after inputs are sampled; LED_INDEX_DISPLAY_SWEEP_EN adds a start-up sweep.
module led_index_display
    import led_display_pkg::*;
#(
    parameter int N_LEDS    = 16,
    parameter int IDX_W     = $clog2(N_LEDS),
    parameter int BLINK_DIV = 25_000_000,
    parameter int STEP_DIV  = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic              idx_valid,
    input  logic              start,
    input  logic              idle,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              sweeping
);

    localparam logic [31:0] IDLE_PAT = idle_pattern(N_LEDS);

    if (N_LEDS < 4 || N_LEDS > 32 || BLINK_DIV < 2 || STEP_DIV < 1) begin : g_param_check
        $error("led_index_display: parameter out of range");
    end

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    pos_q, pos_d;
    logic                phase_q, phase_d;
    logic                blink_tick;
    logic [N_LEDS-1:0]   led_d;

    // An index beyond the bar shifts the single bit out, giving an all-dark display.
    function automatic logic [N_LEDS-1:0] one_hot(input logic [IDX_W-1:0] i);
        one_hot = N_LEDS'(1) << i;
    endfunction

    function automatic logic [N_LEDS-1:0] mode_bar(input logic [1:0] m);
        case (mode_t'(m))
            MODE_LOW:  mode_bar = N_LEDS'(3'b001);
            MODE_NORM: mode_bar = N_LEDS'(3'b011);
            MODE_HIGH: mode_bar = N_LEDS'(3'b111);
            default:   mode_bar = IDLE_PAT[N_LEDS-1:0];
        endcase
    endfunction

    tick_divider #(.DIV(BLINK_DIV)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == S_PAUSE),
        .clr  (state_d != S_PAUSE),
        .tick (blink_tick)
    );

`ifdef LED_INDEX_DISPLAY_SWEEP_EN
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             step_tick;
    logic             sweep_done;

    tick_divider #(.DIV(STEP_DIV)) u_step (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == S_SWEEP),
        .clr  (state_d != S_SWEEP),
        .tick (step_tick)
    );

    assign sweep_done = step_tick && (sweep_q == IDX_W'(N_LEDS - 1));
    assign sweep_d    = (state_q != S_SWEEP) ? '0 : sweep_q + IDX_W'(step_tick);

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_q  <= '0;
            sweeping <= 1'b0;
        end else begin
            sweep_q  <= sweep_d;
            sweeping <= (state_d == S_SWEEP);
        end
    end
`else
    assign sweeping = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pos_d   = idx_valid ? idx : pos_q;
        if (!start) begin
            state_d = S_MODE;
        end else begin
            case (state_q)
`ifdef LED_INDEX_DISPLAY_SWEEP_EN
                S_MODE:  state_d = S_SWEEP;
                S_SWEEP: if (sweep_done) state_d = idle ? S_PAUSE : S_RUN;
`else
                S_MODE:  state_d = idle ? S_PAUSE : S_RUN;
`endif
                S_RUN, S_PAUSE: state_d = idle ? S_PAUSE : S_RUN;
                default: state_d = S_MODE;
            endcase
        end

        // Phase is forced dark outside pause so every new pause starts with a full dark half-period.
        phase_d = (state_d == S_PAUSE) ? (phase_q ^ blink_tick) : 1'b0;

        case (state_d)
            S_MODE:  led_d = mode_bar(mode);
            S_RUN:   led_d = one_hot(pos_d);
            S_PAUSE: led_d = phase_d ? one_hot(pos_d) : '0;
`ifdef LED_INDEX_DISPLAY_SWEEP_EN
            S_SWEEP: led_d = one_hot(sweep_d);
`endif
            default: led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_MODE;
            pos_q   <= '0;
            phase_q <= 1'b0;
            led     <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            led     <= led_d;
        end
    end

endmodule

// File: tb/tb_led_index_display.sv
// Bench for led_index_display: a 16-LED and a 12-LED instance share stimulus; a scoreboard
// queue holds the expected registered outputs and a negedge monitor pops and compares them.
module tb_led_index_display;
    import led_display_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        idle = 1'b0;
    logic        idx_valid = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  idx = 4'd0;
    logic [15:0] led16;
    logic [11:0] led12;
    logic        sw16, sw12;

    typedef struct packed {
        logic [15:0] e16;
        logic [11:0] e12;
        logic        esw;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    led_index_display #(.N_LEDS(16), .BLINK_DIV(4), .STEP_DIV(2)) u_dut16 (
        .clk(clk), .rst(rst), .idx(idx), .idx_valid(idx_valid), .start(start),
        .idle(idle), .mode(mode), .led(led16), .sweeping(sw16)
    );

    led_index_display #(.N_LEDS(12), .BLINK_DIV(4), .STEP_DIV(2)) u_dut12 (
        .clk(clk), .rst(rst), .idx(idx), .idx_valid(idx_valid), .start(start),
        .idle(idle), .mode(mode), .led(led12), .sweeping(sw12)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%04h, want 0x%04h (t=%0t)", name, got, want, $time);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("led16", led16, e.e16);
            check("led12", {4'h0, led12}, {4'h0, e.e12});
            check("sweeping16", {15'h0, sw16}, {15'h0, e.esw});
            check("sweeping12", {15'h0, sw12}, {15'h0, e.esw});
        end
    end

    // Called just after a negedge: drive inputs, let the DUT sample them, queue the expected response.
    task automatic step(input logic r, input logic s, input logic i, input logic [1:0] m,
                        input logic v, input logic [3:0] x,
                        input logic [15:0] e16, input logic [11:0] e12);
        rst = r; start = s; idle = i; mode = m; idx_valid = v; idx = x;
        @(posedge clk);
        q.push_back('{e16: e16, e12: e12, esw: 1'b0});
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset with start/mode active must still show dark LEDs.
        repeat (2) step(1, 1, 0, 2'd3, 0, 4'd0, 16'h0000, 12'h000);
        // Idle pattern, then mode bars.
        step(0, 0, 0, 2'd0, 0, 4'd0, 16'h1FF8, 12'h1F8);
        step(0, 0, 0, 2'd1, 0, 4'd0, 16'h0001, 12'h001);
        step(0, 0, 0, 2'd2, 0, 4'd0, 16'h0003, 12'h003);
        step(0, 0, 0, 2'd3, 0, 4'd0, 16'h0007, 12'h007);
        // Latch in S_MODE, then run shows it.
        step(0, 0, 0, 2'd3, 1, 4'd3, 16'h0007, 12'h007);
        step(0, 1, 0, 2'd3, 0, 4'd0, 16'h0008, 12'h008);
        step(0, 1, 0, 2'd3, 1, 4'd9, 16'h0200, 12'h200);
        step(0, 1, 0, 2'd1, 0, 4'd0, 16'h0200, 12'h200);
        step(0, 1, 0, 2'd1, 1, 4'd15, 16'h8000, 12'h000);
        step(0, 1, 0, 2'd1, 1, 4'd13, 16'h2000, 12'h000);
        step(0, 1, 0, 2'd1, 1, 4'd11, 16'h0800, 12'h800);
        // Pause together with a new index: dark 4, lit 4, dark 4, lit 2.
        step(0, 1, 1, 2'd1, 1, 4'd5, 16'h0000, 12'h000);
        repeat (3) step(0, 1, 1, 2'd1, 0, 4'd0, 16'h0000, 12'h000);
        repeat (4) step(0, 1, 1, 2'd1, 0, 4'd0, 16'h0020, 12'h020);
        repeat (4) step(0, 1, 1, 2'd1, 0, 4'd0, 16'h0000, 12'h000);
        repeat (2) step(0, 1, 1, 2'd1, 0, 4'd0, 16'h0020, 12'h020);
        // Resume clears the blink counter; the next pause starts dark again.
        step(0, 1, 0, 2'd1, 0, 4'd0, 16'h0020, 12'h020);
        repeat (4) step(0, 1, 1, 2'd2, 0, 4'd0, 16'h0000, 12'h000);
        step(0, 1, 1, 2'd0, 0, 4'd0, 16'h0020, 12'h020);
        // start falls with idx_valid: mode bar shown, index kept.
        step(0, 0, 1, 2'd2, 1, 4'd7, 16'h0003, 12'h003);
        step(0, 1, 0, 2'd2, 0, 4'd0, 16'h0080, 12'h080);
        repeat (4) step(0, 1, 1, 2'd2, 0, 4'd0, 16'h0000, 12'h000);
        step(0, 1, 1, 2'd2, 0, 4'd0, 16'h0080, 12'h080);
        // Reset mid-pause, then index and blink counter must be back at zero.
        step(1, 1, 1, 2'd2, 0, 4'd0, 16'h0000, 12'h000);
        step(0, 0, 0, 2'd0, 0, 4'd0, 16'h1FF8, 12'h1F8);
        repeat (4) step(0, 1, 1, 2'd0, 0, 4'd0, 16'h0000, 12'h000);
        step(0, 1, 1, 2'd0, 0, 4'd0, 16'h0001, 12'h001);
        step(0, 1, 0, 2'd0, 0, 4'd0, 16'h0001, 12'h001);
        step(0, 0, 0, 2'd1, 0, 4'd0, 16'h0001, 12'h001);

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
